// File: rtl/credit_sink_buf.sv
// credit_sink_buf: credit-pipeline sink FIFO with an input-side 1..SEQ_MAX sequence checker.
module credit_sink_buf #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int SEQ_MAX = 400
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_genfifo_req_i,
    input  logic [WIDTH-1:0]         in_genfifo_wdata_bi,
    output logic                     in_genfifo_ack_o,
    output logic                     out_genfifo_req_o,
    output logic [WIDTH-1:0]         out_genfifo_rdata_bo,
    input  logic                     out_genfifo_ack_i,
    output logic                     seq_err_o,
    output logic [15:0]              err_cnt_o,
    output logic [31:0]              rx_cnt_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [0:0] ST_SYNC  = 1'b0;
    localparam logic [0:0] ST_CHECK = 1'b1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d, nxt;
    logic             seq_err_q, seq_err_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic [31:0]      rx_cnt_q, rx_cnt_d;
    logic             push, pop, mismatch;

    // Acceptance ignores a same-cycle pop so a full buffer never relies on the downstream.
    assign in_genfifo_ack_o     = rst_i && in_genfifo_req_i && (level_q != FULL);
    assign push                 = in_genfifo_req_i && in_genfifo_ack_o;
    assign pop                  = (level_q != '0) && out_genfifo_ack_i;
    assign out_genfifo_req_o    = level_q != '0;
    assign out_genfifo_rdata_bo = mem_q[rd_ptr_q];
    assign level_o              = level_q;
    assign seq_err_o            = seq_err_q;
    assign err_cnt_o            = err_cnt_q;
    assign rx_cnt_o             = rx_cnt_q;

    assign nxt      = (in_genfifo_wdata_bi >= WIDTH'(SEQ_MAX)) ? WIDTH'(1) : in_genfifo_wdata_bi + WIDTH'(1);
    assign mismatch = push && (state_q == ST_CHECK) && (in_genfifo_wdata_bi != exp_q);

    always_comb begin
        wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d   = level_q + (AW+1)'(push) - (AW+1)'(pop);
        state_d   = push ? ST_CHECK : state_q;
        exp_d     = push ? nxt : exp_q;
        seq_err_d = seq_err_q || mismatch;
        err_cnt_d = (mismatch && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
        rx_cnt_d  = rx_cnt_q + 32'(push);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            state_q   <= ST_SYNC;
            exp_q     <= '0;
            seq_err_q <= 1'b0;
            err_cnt_q <= '0;
            rx_cnt_q  <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            state_q   <= state_d;
            exp_q     <= exp_d;
            seq_err_q <= seq_err_d;
            err_cnt_q <= err_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= in_genfifo_wdata_bi;
    end
endmodule

// File: tb/tb_credit_sink_buf.sv
// tb_credit_sink_buf: directed and randomised-ack checks of credit_sink_buf.
module tb_credit_sink_buf;
    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        req_i = 1'b0;
    logic [15:0] wdata = '0;
    logic        ack_o;
    logic        oreq;
    logic [15:0] rdata;
    logic        oack = 1'b0;
    logic        seq_err;
    logic [15:0] err_cnt;
    logic [31:0] rx_cnt;
    logic [2:0]  level;

    int checks = 0;
    int failures = 0;

    logic [15:0] q[$];
    logic        obs_ack, obs_oreq, exp_oreq;
    logic [15:0] obs_rdata;

    credit_sink_buf #(.WIDTH(16), .DEPTH(4), .SEQ_MAX(400)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .in_genfifo_req_i(req_i), .in_genfifo_wdata_bi(wdata), .in_genfifo_ack_o(ack_o),
        .out_genfifo_req_o(oreq), .out_genfifo_rdata_bo(rdata), .out_genfifo_ack_i(oack),
        .seq_err_o(seq_err), .err_cnt_o(err_cnt), .rx_cnt_o(rx_cnt), .level_o(level)
    );

    always #5 clk = ~clk;

    // Drives one cycle, captures the pre-edge outputs and advances the reference queue.
    task automatic apply_cycle(input logic r, input logic [15:0] d, input logic a);
        logic p, o;
        req_i = r;
        wdata = d;
        oack = a;
        #1;
        obs_ack = ack_o;
        obs_oreq = oreq;
        obs_rdata = rdata;
        exp_oreq = q.size() != 0;
        p = r && (q.size() < 4);
        o = (q.size() != 0) && a;
        @(posedge clk);
        if (o) void'(q.pop_front());
        if (p) q.push_back(d);
        #1;
    endtask

    task automatic do_reset();
        req_i = 1'b0;
        oack = 1'b0;
        rst_i = 1'b0;
        #2;
        q.delete();
        rst_i = 1'b1;
    endtask

    task automatic test_reset();
        req_i = 1'b1;
        wdata = 16'd1;
        #1;
        checks++; if (ack_o !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b want=0", ack_o); end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL rst_level got=%0d want=0", level); end
        checks++; if (oreq !== 1'b0) begin failures++; $display("FAIL rst_oreq got=%b want=0", oreq); end
        checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL rst_seq_err got=%b want=0", seq_err); end
        checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL rst_err_cnt got=%0d want=0", err_cnt); end
        checks++; if (rx_cnt !== 32'd0) begin failures++; $display("FAIL rst_rx_cnt got=%0d want=0", rx_cnt); end
        @(posedge clk);
        #1;
        do_reset();
    endtask

    task automatic test_stream();
        logic [15:0] w, nout;
        do_reset();
        nout = 16'd1;
        for (int i = 0; i < 403; i++) begin
            w = (i < 400) ? 16'(i + 1) : 16'(i - 399);
            apply_cycle(i < 402, w, 1'b1);
            checks++; if (obs_ack !== (i < 402)) begin failures++; $display("FAIL stream_ack cyc=%0d got=%b want=%b", i, obs_ack, i < 402); end
            checks++; if (obs_oreq !== (i != 0)) begin failures++; $display("FAIL stream_oreq cyc=%0d got=%b want=%b", i, obs_oreq, i != 0); end
            if (i != 0) begin
                checks++; if (obs_rdata !== nout) begin failures++; $display("FAIL stream_data cyc=%0d got=%0d want=%0d", i, obs_rdata, nout); end
                nout = (nout == 16'd400) ? 16'd1 : nout + 16'd1;
            end
        end
        checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL stream_err_cnt got=%0d want=0", err_cnt); end
        checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL stream_seq_err got=%b want=0", seq_err); end
        checks++; if (rx_cnt !== 32'd402) begin failures++; $display("FAIL stream_rx_cnt got=%0d want=402", rx_cnt); end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL stream_level got=%0d want=0", level); end
    endtask

    task automatic test_backpressure();
        logic [15:0] w, nout;
        do_reset();
        w = 16'd1;
        for (int c = 0; c < 6; c++) begin
            apply_cycle(1'b1, w, 1'b0);
            checks++; if (obs_ack !== (c < 4)) begin failures++; $display("FAIL bp_ack cyc=%0d got=%b want=%b", c, obs_ack, c < 4); end
            if (obs_ack) w++;
        end
        checks++; if (level !== 3'd4) begin failures++; $display("FAIL bp_level got=%0d want=4", level); end
        checks++; if (rdata !== 16'd1) begin failures++; $display("FAIL bp_head got=%0d want=1", rdata); end
        apply_cycle(1'b1, w, 1'b1);
        checks++; if (obs_ack !== 1'b0) begin failures++; $display("FAIL full_pop_ack got=%b want=0", obs_ack); end
        checks++; if (obs_rdata !== 16'd1) begin failures++; $display("FAIL full_pop_data got=%0d want=1", obs_rdata); end
        checks++; if (level !== 3'd3) begin failures++; $display("FAIL full_pop_level got=%0d want=3", level); end
        nout = 16'd2;
        for (int c = 0; c < 12 && nout <= 16'd6; c++) begin
            apply_cycle(w <= 16'd6, w, 1'b1);
            if (obs_ack) w++;
            if (obs_oreq) begin
                checks++; if (obs_rdata !== nout) begin failures++; $display("FAIL bp_order got=%0d want=%0d", obs_rdata, nout); end
                nout++;
            end
        end
        checks++; if (nout !== 16'd7) begin failures++; $display("FAIL bp_drain_count got=%0d want=7", nout); end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL bp_end_level got=%0d want=0", level); end
        checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL bp_err_cnt got=%0d want=0", err_cnt); end
        checks++; if (rx_cnt !== 32'd6) begin failures++; $display("FAIL bp_rx_cnt got=%0d want=6", rx_cnt); end
    endtask

    task automatic test_mismatch();
        logic [15:0] words [4];
        logic [15:0] werr [4];
        logic        wseq [4];
        words = '{16'd5, 16'd6, 16'd8, 16'd9};
        werr  = '{16'd0, 16'd0, 16'd1, 16'd1};
        wseq  = '{1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply_cycle(1'b1, words[i], 1'b1);
            checks++; if (err_cnt !== werr[i]) begin failures++; $display("FAIL mm_err_cnt word=%0d got=%0d want=%0d", words[i], err_cnt, werr[i]); end
            checks++; if (seq_err !== wseq[i]) begin failures++; $display("FAIL mm_seq_err word=%0d got=%b want=%b", words[i], seq_err, wseq[i]); end
        end
        checks++; if (rx_cnt !== 32'd4) begin failures++; $display("FAIL mm_rx_cnt got=%0d want=4", rx_cnt); end
    endtask

    task automatic test_random();
        logic [15:0] w, nout;
        logic        a;
        do_reset();
        w = 16'd1;
        nout = 16'd1;
        for (int c = 0; c < 4000; c++) begin
            a = $urandom_range(0, 9) == 0;
            apply_cycle(1'b1, w, a);
            if (obs_ack) w = (w == 16'd400) ? 16'd1 : w + 16'd1;
            checks++; if (obs_oreq !== exp_oreq) begin failures++; $display("FAIL rnd_oreq cyc=%0d got=%b want=%b", c, obs_oreq, exp_oreq); end
            if (obs_oreq && a) begin
                checks++; if (obs_rdata !== nout) begin failures++; $display("FAIL rnd_order cyc=%0d got=%0d want=%0d", c, obs_rdata, nout); end
                nout = (nout == 16'd400) ? 16'd1 : nout + 16'd1;
            end
            checks++; if (level > 3'd4 || 32'(level) !== q.size()) begin failures++; $display("FAIL rnd_level cyc=%0d got=%0d want=%0d", c, level, q.size()); end
        end
        checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL rnd_err_cnt got=%0d want=0", err_cnt); end
        checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL rnd_seq_err got=%b want=0", seq_err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 1; i <= 3; i++) apply_cycle(1'b1, 16'(i + 40), 1'b0);
        checks++; if (level !== 3'd3) begin failures++; $display("FAIL mid_pre_level got=%0d want=3", level); end
        rst_i = 1'b0;
        req_i = 1'b1;
        #1;
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL mid_level got=%0d want=0", level); end
        checks++; if (oreq !== 1'b0) begin failures++; $display("FAIL mid_oreq got=%b want=0", oreq); end
        checks++; if (ack_o !== 1'b0) begin failures++; $display("FAIL mid_ack got=%b want=0", ack_o); end
        q.delete();
        rst_i = 1'b1;
        apply_cycle(1'b1, 16'd7, 1'b1);
        checks++; if (obs_ack !== 1'b1) begin failures++; $display("FAIL mid_first_push got=%b want=1", obs_ack); end
        checks++; if (oreq !== 1'b1 || rdata !== 16'd7) begin failures++; $display("FAIL mid_head got=%b/%0d want=1/7", oreq, rdata); end
        apply_cycle(1'b1, 16'd8, 1'b1);
        apply_cycle(1'b0, 16'd0, 1'b1);
        checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL mid_err_cnt got=%0d want=0", err_cnt); end
        checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL mid_seq_err got=%b want=0", seq_err); end
        checks++; if (rx_cnt !== 32'd2) begin failures++; $display("FAIL mid_rx_cnt got=%0d want=2", rx_cnt); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_mismatch();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/credit_sink_buf.md
CREDIT_SINK_BUF -- requirements
Module: credit_sink_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning data word width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning buffer entries (power of two, >=2).
REQ-003 SHALL have parameter SEQ_MAX, default 400, meaning last value of the expected sequence 1..SEQ_MAX.
REQ-004 SHALL have port clk_i  input  1  clock, all state on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_genfifo_req_i  input  1  upstream (credit pipeline dataout) word valid.
REQ-007 SHALL have port in_genfifo_wdata_bi  input  WIDTH  upstream word.
REQ-008 SHALL have port in_genfifo_ack_o  output  1  word accepted this cycle.
REQ-009 SHALL have port out_genfifo_req_o  output  1  buffered word available.
REQ-010 SHALL have port out_genfifo_rdata_bo  output  WIDTH  head word.
REQ-011 SHALL have port out_genfifo_ack_i  input  1  downstream takes head word.
REQ-012 SHALL have port seq_err_o  output  1  sticky: any sequence mismatch since reset.
REQ-013 SHALL have port err_cnt_o  output  16  mismatch count, saturating.
REQ-014 SHALL have port rx_cnt_o  output  32  accepted-word count, wrapping.
REQ-015 SHALL have port level_o  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 SHALL accept a word (push) when in_genfifo_req_i && in_genfifo_ack_o on a rising edge.
REQ-017 SHALL drive in_genfifo_ack_o = in_genfifo_req_i && (level_o < DEPTH), combinationally; no push on full even if a pop occurs the same cycle.
REQ-018 SHALL drive out_genfifo_req_o = (level_o != 0), registered state only; no empty bypass, so push-to-req latency is 1 cycle.
REQ-019 SHALL pop when out_genfifo_req_o && out_genfifo_ack_i; out_genfifo_ack_i while empty SHALL be ignored.
REQ-020 SHALL keep out_genfifo_rdata_bo equal to the oldest unpopped word, stable until popped; value is don't-care when empty.
REQ-021 SHALL preserve order; simultaneous push and pop with 0<level<DEPTH SHALL leave level unchanged.
REQ-022 SHALL use read/write pointers wrapping modulo DEPTH.
REQ-023 SHALL run a checker FSM on pushed words, states SYNC and CHECK.
REQ-024 In SYNC, first push SHALL load expected = next(word) and move to CHECK; no error counted.
REQ-025 In CHECK, each push SHALL compare word to expected; on mismatch set seq_err_o, increment err_cnt_o (hold at 16'hFFFF), and reload expected = next(word); on match expected = next(word).
REQ-026 next(x) SHALL be 1 when x >= SEQ_MAX, else x+1, computed in WIDTH bits.
REQ-027 rx_cnt_o SHALL increment by 1 per push, wrapping 2^32-1 -> 0.
REQ-028 Checker SHALL observe only the input side; downstream stalls SHALL not affect it.

Reset
REQ-029 On rst_i low, asynchronously: pointers and level_o=0, out_genfifo_req_o=0, checker=SYNC, expected=0, seq_err_o=0, err_cnt_o=0, rx_cnt_o=0.
REQ-030 Reset mid-operation SHALL discard all buffered words; in_genfifo_ack_o SHALL be 0 while rst_i is low.
REQ-031 First push SHALL be possible on the first rising edge after rst_i deasserts.

Verification
REQ-032 Stream 1,2,...,400,1,2 with out_genfifo_ack_i=1 -> words out in order 1 cycle after push, err_cnt_o=0, seq_err_o=0, rx_cnt_o=402.
REQ-033 Hold out_genfifo_ack_i=0, drive req=1 with 1..6 -> pushes 1..4, level_o=4, ack_o=0 from the 5th cycle; then ack_i=1 -> out 1,2,3,4 then 5,6.
REQ-034 Level 4, req=1 and ack_i=1 same cycle -> pop occurs, push refused, level_o=3.
REQ-035 Stream 5,6,8,9 -> first word syncs, one mismatch at 8, err_cnt_o=1, seq_err_o=1, 9 accepted without new error.
REQ-036 Random ack_i (10% high), 4000 cycles of 1..400 wrap -> output matches input order, err_cnt_o=0, level_o never exceeds 4.
REQ-037 Assert rst_i low with level_o=3 -> level_o=0, out_genfifo_req_o=0 immediately; after release, stream 7,8 -> no error (SYNC on 7).
